// File: rtl/toy_mext_arb_if.sv
// Bundle of the two issue request channels, the M-extension datapath
// operand bus and the writeback readiness input.
interface toy_mext_arb_if #(
  parameter int INST_WIDTH     = 32,
  parameter int INST_IDX_WIDTH = 8,
  parameter int REG_WIDTH      = 32
);
  logic                      req0_vld;
  logic                      req0_rdy;
  logic [INST_WIDTH-1:0]     req0_pld;
  logic [INST_IDX_WIDTH-1:0] req0_idx;
  logic [4:0]                req0_rd_idx;
  logic                      req0_rd_en;
  logic [REG_WIDTH-1:0]      req0_rs1;
  logic [REG_WIDTH-1:0]      req0_rs2;

  logic                      req1_vld;
  logic                      req1_rdy;
  logic [INST_WIDTH-1:0]     req1_pld;
  logic [INST_IDX_WIDTH-1:0] req1_idx;
  logic [4:0]                req1_rd_idx;
  logic                      req1_rd_en;
  logic [REG_WIDTH-1:0]      req1_rs1;
  logic [REG_WIDTH-1:0]      req1_rs2;

  logic                      mext_vld;
  logic [INST_WIDTH-1:0]     mext_pld;
  logic [INST_IDX_WIDTH-1:0] mext_idx;
  logic [4:0]                mext_rd_idx;
  logic                      mext_rd_en;
  logic [REG_WIDTH-1:0]      mext_rs1;
  logic [REG_WIDTH-1:0]      mext_rs2;
  logic                      mext_src;
  logic                      wb_rdy;

  // Requester / writeback side.
  modport master (
    output req0_vld, req0_pld, req0_idx, req0_rd_idx, req0_rd_en, req0_rs1, req0_rs2,
    input  req0_rdy,
    output req1_vld, req1_pld, req1_idx, req1_rd_idx, req1_rd_en, req1_rs1, req1_rs2,
    input  req1_rdy,
    input  mext_vld, mext_pld, mext_idx, mext_rd_idx, mext_rd_en, mext_rs1, mext_rs2, mext_src,
    output wb_rdy
  );

  // Arbiter side.
  modport slave (
    input  req0_vld, req0_pld, req0_idx, req0_rd_idx, req0_rd_en, req0_rs1, req0_rs2,
    output req0_rdy,
    input  req1_vld, req1_pld, req1_idx, req1_rd_idx, req1_rd_en, req1_rs1, req1_rs2,
    output req1_rdy,
    output mext_vld, mext_pld, mext_idx, mext_rd_idx, mext_rd_en, mext_rs1, mext_rs2, mext_src,
    input  wb_rdy
  );
endinterface

// File: rtl/toy_mext_arb.sv
// Round-robin arbiter/sequencer for the shared M-extension datapath.
// Handshake: a request transfers on a cycle where reqN_vld and reqN_rdy are
// both high; the requester holds payload stable while vld is high and rdy is
// low. mext_vld is a one-cycle pulse, qualified by wb_rdy, that marks the
// single cycle in which the datapath result for the held operands commits.
module toy_mext_arb #(
  parameter int INST_WIDTH     = 32,
  parameter int INST_IDX_WIDTH = 8,
  parameter int REG_WIDTH      = 32,
  parameter int MUL_LAT        = 2,
  parameter int DIV_LAT        = 8,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  toy_mext_arb_if.slave bus,
  output logic          busy,
  output logic          dbg_state,
  output logic [3:0]    dbg_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  typedef struct packed {
    logic [INST_WIDTH-1:0]     pld;
    logic [INST_IDX_WIDTH-1:0] idx;
    logic [4:0]                rd_idx;
    logic                      rd_en;
    logic [REG_WIDTH-1:0]      rs1;
    logic [REG_WIDTH-1:0]      rs2;
  } pkt_t;

  pkt_t          in_pkt [2];
  logic [1:0]    in_vld;
  pkt_t          mem    [2][FIFO_DEPTH];
  logic [PW-1:0] rd_ptr [2];
  logic [PW-1:0] wr_ptr [2];
  logic [PW:0]   count  [2];
  pkt_t          head   [2];
  logic [1:0]    full;
  logic [1:0]    nonempty;
  logic [1:0]    rdy;
  logic [1:0]    push;
  logic [1:0]    pop;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       favour_q;
  logic       grant_ok;
  logic       grant;
  logic       sel;
  logic [3:0] lat_m1;
  logic       vld;
  pkt_t       mext_q;
  logic       src_q;

  // Gather the two request channels into indexable form.
  always_comb begin
    in_vld[0] = bus.req0_vld;
    in_vld[1] = bus.req1_vld;
    in_pkt[0] = '{pld: bus.req0_pld, idx: bus.req0_idx, rd_idx: bus.req0_rd_idx,
                  rd_en: bus.req0_rd_en, rs1: bus.req0_rs1, rs2: bus.req0_rs2};
    in_pkt[1] = '{pld: bus.req1_pld, idx: bus.req1_idx, rd_idx: bus.req1_rd_idx,
                  rd_en: bus.req1_rd_en, rs1: bus.req1_rs1, rs2: bus.req1_rs2};
  end

  // FIFO status, ready and push qualification; flush blocks all pushes.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]     = (count[i] == (PW+1)'(FIFO_DEPTH));
      nonempty[i] = (count[i] != '0);
      rdy[i]      = ~full[i] & ~flush;
      push[i]     = in_vld[i] & rdy[i];
      head[i]     = mem[i][rd_ptr[i]];
    end
  end

  assign bus.req0_rdy = rdy[0];
  assign bus.req1_rdy = rdy[1];

  // FIFO storage; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_pkt[i];
    end
  end

  // FIFO pointers and occupancy; flush empties both queues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Grant selection: a grant slot exists in IDLE or when the current
  // operation completes; the favoured side wins only when both are ready.
  always_comb begin
    grant_ok = ~flush & ((state_q == IDLE) |
                         ((state_q == EXEC) & (cnt_q == 4'd0) & bus.wb_rdy));
    sel      = (nonempty == 2'b11) ? favour_q : nonempty[1];
    grant    = grant_ok & (|nonempty);
    pop      = 2'b00;
    pop[sel] = grant;
    lat_m1   = head[sel].pld[14] ? 4'(DIV_LAT - 1) : 4'(MUL_LAT - 1);
  end

  // State and counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, hold counter and commit pulse; flush overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = EXEC;
          cnt_d   = lat_m1;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          vld = bus.wb_rdy;
          if (bus.wb_rdy) begin
            if (grant) begin
              cnt_d = lat_m1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      vld     = 1'b0;
    end
  end

  // Round-robin pointer flips to the side that lost on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) favour_q <= 1'b0;
    else if (grant) favour_q <= ~sel;
  end

  // Operand registers change only on grant and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mext_q <= '0;
      src_q  <= 1'b0;
    end else if (grant) begin
      mext_q <= head[sel];
      src_q  <= sel;
    end
  end

  assign bus.mext_vld    = vld;
  assign bus.mext_pld    = mext_q.pld;
  assign bus.mext_idx    = mext_q.idx;
  assign bus.mext_rd_idx = mext_q.rd_idx;
  assign bus.mext_rd_en  = mext_q.rd_en;
  assign bus.mext_rs1    = mext_q.rs1;
  assign bus.mext_rs2    = mext_q.rs2;
  assign bus.mext_src    = src_q;

  assign busy      = (state_q != IDLE) | (|nonempty);
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_toy_mext_arb.sv
// Directed bench for toy_mext_arb: a vector table of single operations
// followed by hand-written multi-cycle sequences.
module tb_toy_mext_arb;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       busy;
  logic       dbg_state;
  logic [3:0] dbg_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  toy_mext_arb_if bus ();

  toy_mext_arb dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         src;
    logic [2:0] f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [7:0] idx;
    logic [4:0] rd;
    int         exp_cyc;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] make_pld(input logic [2:0] f3, input logic [4:0] rd);
    return {7'h01, 5'd2, 5'd1, f3, rd, 7'h33};
  endfunction

  // Driver tasks.
  task automatic set_req(input int src, input logic [2:0] f3, input logic [7:0] idx,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    if (src == 0) begin
      bus.req0_vld = 1'b1; bus.req0_pld = make_pld(f3, rd); bus.req0_idx = idx;
      bus.req0_rd_idx = rd; bus.req0_rd_en = 1'b1; bus.req0_rs1 = a; bus.req0_rs2 = b;
    end else begin
      bus.req1_vld = 1'b1; bus.req1_pld = make_pld(f3, rd); bus.req1_idx = idx;
      bus.req1_rd_idx = rd; bus.req1_rd_en = 1'b1; bus.req1_rs1 = a; bus.req1_rs2 = b;
    end
  endtask

  task automatic clr_req(input int src);
    if (src == 0) bus.req0_vld = 1'b0;
    else          bus.req1_vld = 1'b0;
  endtask

  function automatic logic get_rdy(input int src);
    return (src == 0) ? bus.req0_rdy : bus.req1_rdy;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int pulses;
    int vc;
    logic [31:0] g_rs1, g_rs2;
    logic [7:0]  g_idx;
    logic [4:0]  g_rd;
    logic        g_src;
    logic        rdy_third;

    rst = 1'b1; flush = 1'b0; bus.wb_rdy = 1'b1;
    bus.req0_vld = 1'b0; bus.req0_pld = '0; bus.req0_idx = '0; bus.req0_rd_idx = '0;
    bus.req0_rd_en = 1'b0; bus.req0_rs1 = '0; bus.req0_rs2 = '0;
    bus.req1_vld = 1'b0; bus.req1_pld = '0; bus.req1_idx = '0; bus.req1_rd_idx = '0;
    bus.req1_rd_en = 1'b0; bus.req1_rs1 = '0; bus.req1_rs2 = '0;

    vecs[0] = '{src: 0, f3: 3'b000, rs1: 32'd7,        rs2: 32'd6,        idx: 8'h05, rd: 5'd3,  exp_cyc: 3};
    vecs[1] = '{src: 1, f3: 3'b001, rs1: 32'hdead0001, rs2: 32'h0000beef, idx: 8'h11, rd: 5'd9,  exp_cyc: 3};
    vecs[2] = '{src: 0, f3: 3'b100, rs1: 32'd100,      rs2: 32'd7,        idx: 8'h22, rd: 5'd12, exp_cyc: 9};
    vecs[3] = '{src: 1, f3: 3'b111, rs1: 32'h80000000, rs2: 32'd3,        idx: 8'h33, rd: 5'd31, exp_cyc: 9};
    vecs[4] = '{src: 0, f3: 3'b011, rs1: 32'hffffffff, rs2: 32'hffffffff, idx: 8'hff, rd: 5'd1,  exp_cyc: 3};

    // Reset values.
    @(negedge clk);
    chk("rst_mext_vld", 64'(bus.mext_vld), 0);
    chk("rst_mext_src", 64'(bus.mext_src), 0);
    chk("rst_mext_rs1", 64'(bus.mext_rs1), 0);
    chk("rst_mext_idx", 64'(bus.mext_idx), 0);
    chk("rst_busy",     64'(busy), 0);
    chk("rst_state",    64'(dbg_state), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy0", 64'(bus.req0_rdy), 1);
    chk("rst_rdy1", 64'(bus.req1_rdy), 1);
    step();

    // Table: single operation latency and operand delivery.
    for (int i = 0; i < 5; i++) begin
      pulses = 0; vc = -1;
      g_rs1 = '0; g_rs2 = '0; g_idx = '0; g_rd = '0; g_src = 1'b0;
      set_req(vecs[i].src, vecs[i].f3, vecs[i].idx, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), 64'(get_rdy(vecs[i].src)), 1);
      step();
      clr_req(vecs[i].src);
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (bus.mext_vld) begin
          pulses++;
          if (vc < 0) begin
            vc = c; g_rs1 = bus.mext_rs1; g_rs2 = bus.mext_rs2;
            g_idx = bus.mext_idx; g_rd = bus.mext_rd_idx; g_src = bus.mext_src;
          end
        end
        step();
      end
      chk($sformatf("v%0d_lat", i),    64'(vc), 64'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_pulses", i), 64'(pulses), 1);
      chk($sformatf("v%0d_rs1", i),    64'(g_rs1), 64'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2", i),    64'(g_rs2), 64'(vecs[i].rs2));
      chk($sformatf("v%0d_idx", i),    64'(g_idx), 64'(vecs[i].idx));
      chk($sformatf("v%0d_rd", i),     64'(g_rd),  64'(vecs[i].rd));
      chk($sformatf("v%0d_src", i),    64'(g_src), 64'(vecs[i].src));
    end

    // Simultaneous DIVs: req0 first (cycle 9), req1 back-to-back (cycle 17).
    do_reset();
    set_req(0, 3'b100, 8'h61, 32'd50, 32'd5, 5'd4);
    set_req(1, 3'b101, 8'h62, 32'd60, 32'd6, 5'd5);
    step();
    clr_req(0); clr_req(1);
    begin
      int v0, v1; logic s0, s1; logic [7:0] i0, i1;
      pulses = 0; v0 = -1; v1 = -1; s0 = 1'bx; s1 = 1'bx; i0 = '0; i1 = '0;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (bus.mext_vld) begin
          pulses++;
          if (pulses == 1) begin v0 = c; s0 = bus.mext_src; i0 = bus.mext_idx; end
          if (pulses == 2) begin v1 = c; s1 = bus.mext_src; i1 = bus.mext_idx; end
        end
        step();
      end
      chk("sim_pulses", 64'(pulses), 2);
      chk("sim_cyc0",   64'(v0), 9);
      chk("sim_src0",   64'(s0), 0);
      chk("sim_idx0",   64'(i0), 64'h61);
      chk("sim_cyc1",   64'(v1), 17);
      chk("sim_src1",   64'(s1), 1);
      chk("sim_idx1",   64'(i1), 64'h62);
    end

    // Backpressure: req0 queues 3 MULs behind a DIV from req1.
    do_reset();
    exp_q = {8'h20, 8'h0a, 8'h0b, 8'h0c};
    rdy_third = 1'bx;
    fork
      begin
        set_req(1, 3'b100, 8'h20, 32'd9, 32'd3, 5'd6);
        step();
        clr_req(1);
        step();
        for (int t = 0; t < 3; t++) begin
          logic r;
          int   bound;
          bound = 0;
          set_req(0, 3'b000, 8'(10 + t), 32'(t), 32'd2, 5'd7);
          forever begin
            @(negedge clk);
            r = bus.req0_rdy;
            if (t == 2 && bound == 0) rdy_third = r;
            step();
            if (r) break;
            bound++;
            if (bound > 30) begin
              chk("bp_push_timeout", 64'(bound), 0);
              break;
            end
          end
        end
        clr_req(0);
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (bus.mext_vld) begin
            if (exp_q.size() == 0) chk("bp_extra_commit", 64'(bus.mext_idx), 64'hfff);
            else chk("bp_commit_idx", 64'(bus.mext_idx), 64'(exp_q.pop_front()));
          end
        end
      end
    join
    chk("bp_rdy_dropped", 64'(rdy_third), 0);
    chk("bp_all_commit",  64'(exp_q.size()), 0);

    // Writeback stall: wb_rdy low in cycles 3..6, single pulse in cycle 7.
    do_reset();
    set_req(0, 3'b010, 8'h40, 32'h11, 32'h22, 5'd8);
    step();
    clr_req(0);
    pulses = 0; vc = -1;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) bus.wb_rdy = 1'b0;
      if (c == 7) bus.wb_rdy = 1'b1;
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        chk($sformatf("stall_vld_c%0d", c), 64'(bus.mext_vld), 0);
        chk($sformatf("stall_rs1_c%0d", c), 64'(bus.mext_rs1), 64'h11);
        chk($sformatf("stall_rs2_c%0d", c), 64'(bus.mext_rs2), 64'h22);
      end
      if (bus.mext_vld) begin
        pulses++;
        if (vc < 0) vc = c;
      end
      step();
    end
    chk("stall_pulses", 64'(pulses), 1);
    chk("stall_cyc",    64'(vc), 7);

    // Flush in cycle 4 of a DIV with req1 queued; new req1 in cycle 5.
    do_reset();
    set_req(0, 3'b100, 8'h30, 32'd1, 32'd1, 5'd10);
    set_req(1, 3'b000, 8'h31, 32'd2, 32'd2, 5'd11);
    step();
    clr_req(0); clr_req(1);
    pulses = 0; vc = -1; g_idx = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 4) flush = 1'b1;
      if (c == 5) begin
        flush = 1'b0;
        set_req(1, 3'b000, 8'h32, 32'h55, 32'h66, 5'd12);
      end
      if (c == 6) clr_req(1);
      @(negedge clk);
      if (c == 4) begin
        chk("fl_vld_c4",  64'(bus.mext_vld), 0);
        chk("fl_rdy0_c4", 64'(bus.req0_rdy), 0);
        chk("fl_rdy1_c4", 64'(bus.req1_rdy), 0);
      end
      if (c == 5) begin
        chk("fl_busy_c5",  64'(busy), 0);
        chk("fl_state_c5", 64'(dbg_state), 0);
        chk("fl_rdy1_c5",  64'(bus.req1_rdy), 1);
      end
      if (c == 6) chk("fl_state_c6", 64'(dbg_state), 0);
      if (c == 7) begin
        chk("fl_state_c7", 64'(dbg_state), 1);
        chk("fl_src_c7",   64'(bus.mext_src), 1);
        chk("fl_idx_c7",   64'(bus.mext_idx), 64'h32);
      end
      if (bus.mext_vld) begin
        pulses++;
        if (vc < 0) begin vc = c; g_idx = bus.mext_idx; end
      end
      step();
    end
    chk("fl_pulses",   64'(pulses), 1);
    chk("fl_vld_cyc",  64'(vc), 8);
    chk("fl_vld_idx",  64'(g_idx), 64'h32);

    // Reset asserted mid-EXEC aborts the operation.
    do_reset();
    set_req(1, 3'b100, 8'h50, 32'h77, 32'h88, 5'd13);
    step();
    clr_req(1);
    step(); step(); step();
    @(negedge clk);
    chk("mr_pre_state", 64'(dbg_state), 1);
    chk("mr_pre_src",   64'(bus.mext_src), 1);
    step();
    rst = 1'b1;
    #1;
    chk("mr_state", 64'(dbg_state), 0);
    chk("mr_cnt",   64'(dbg_cnt), 0);
    chk("mr_vld",   64'(bus.mext_vld), 0);
    chk("mr_src",   64'(bus.mext_src), 0);
    chk("mr_rs1",   64'(bus.mext_rs1), 0);
    chk("mr_idx",   64'(bus.mext_idx), 0);
    chk("mr_busy",  64'(busy), 0);
    step();
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.mext_vld) pulses++;
      step();
    end
    chk("mr_no_vld", 64'(pulses), 0);
    chk("mr_rdy1",   64'(bus.req1_rdy), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toy_mext_arb.md
# toy_mext_arb

Arbiter and sequencer for the shared M-extension datapath. It accepts multiply/divide instructions from two issue requesters, buffers each in a small per-requester FIFO, and grants them round-robin to the single datapath. It holds the selected operands stable for a funct3-dependent number of cycles so the datapath can be timed as a multicycle path. It then pulses one commit-qualifying valid to the datapath, gated by writeback readiness, and reports which requester owns that result.

## Interface
- INST_WIDTH, 32, instruction payload width
- INST_IDX_WIDTH, 8, instruction tag width
- REG_WIDTH, 32, operand width
- MUL_LAT, 2, cycles operands are held for funct3[2]=0 (MUL/MULH/MULHSU/MULHU); legal 1..15
- DIV_LAT, 8, cycles operands are held for funct3[2]=1 (DIV/DIVU/REM/REMU); legal 1..15
- FIFO_DEPTH, 2, entries per requester FIFO; power of two, ≥2

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous kill of all queued and in-flight work
- reqN_vld  in  1  request valid, for N=0,1
- reqN_rdy  out  1  request ready = FIFO not full and !flush
- reqN_pld  in  INST_WIDTH  instruction; funct3 = bits [14:12]
- reqN_idx  in  INST_IDX_WIDTH  instruction tag
- reqN_rd_idx  in  5  destination register
- reqN_rd_en  in  1  destination write enable
- reqN_rs1, reqN_rs2  in  REG_WIDTH  source operands
- mext_vld  out  1  datapath valid; single-cycle pulse per operation
- mext_pld, mext_idx, mext_rd_idx, mext_rd_en, mext_rs1, mext_rs2  out  as above  registered operands to the datapath
- mext_src  out  1  requester that owns the current operation
- wb_rdy  in  1  writeback port can take a result this cycle
- busy  out  1  state != IDLE or any FIFO non-empty

## Operation
- Each requester has a FIFO of {pld, idx, rd_idx, rd_en, rs1, rs2}. A push occurs when reqN_vld & reqN_rdy. A pop occurs on grant.
- States are IDLE and EXEC, with a 4-bit counter cnt.
- IDLE: if any FIFO head is valid, grant one requester.
  - Round-robin: a requester with a valid head wins if it is the only one, otherwise the favoured requester wins.
  - The favoured requester starts as 0 after reset and flips to the non-granted side after every grant.
  - On grant: load the mext_* registers from the FIFO head, set mext_src, set cnt = LAT-1 with LAT selected by funct3[2], and go to EXEC.
- EXEC, cnt≠0: decrement cnt. mext_vld=0.
- EXEC, cnt==0: mext_vld = wb_rdy.
  - If wb_rdy=0, stay in EXEC with operands held and retry the next cycle.
  - If wb_rdy=1, the operation completes. If a FIFO head is valid in that cycle, grant it at the same edge (back-to-back, no IDLE bubble). Otherwise go to IDLE.
- mext_* operand outputs change only on grant; they hold their last value in IDLE.
- flush, highest priority:
  - empties both FIFOs and forces IDLE at the next edge.
  - forces mext_vld=0 in the same cycle.
  - makes reqN_rdy=0, so nothing pushes that cycle.
  - leaves the round-robin pointer unchanged.
- A simultaneous push and pop on a full FIFO is not allowed (rdy=0 when full). On a non-full FIFO, push and pop in the same cycle are both performed.

## Timing
- Reset values:
  - state=IDLE, cnt=0, FIFOs empty, favoured requester=0.
  - mext_vld=0, mext_src=0, all mext_* operands 0, busy=0.
  - reqN_rdy=1 once rst is low.
- Latency: a request accepted in cycle 0 with the other side empty and the arbiter in IDLE is granted in cycle 1. Operands appear in cycle 2. mext_vld is high in cycle LAT+1 (MUL_LAT=2 gives cycle 3; DIV_LAT=8 gives cycle 9), assuming wb_rdy=1.
- Throughput: one operation per LAT cycles when back-to-back.
- mext_vld is never high in two consecutive cycles for the same operation.
- Asserting rst mid-EXEC aborts immediately; no mext_vld is produced for that operation.

## Test plan
- Single MUL on req0, MUL_LAT=2, wb_rdy=1:
  - req0 pld funct3=000, rs1=7, rs2=6, idx=5 accepted in cycle 0.
  - Required: mext_vld=1 only in cycle 3 with mext_rs1=7, mext_rs2=6, mext_idx=5, mext_src=0.
- Simultaneous requests: req0 and req1 both valid in cycle 0 with DIVs, DIV_LAT=8.
  - Required: req0 granted first (mext_vld in cycle 9, src=0).
  - Then req1 granted at that same edge, with mext_vld in cycle 17, src=1.
- Backpressure: req0 pushes 3 MULs in consecutive cycles while the arbiter is busy with a long DIV.
  - Required: req0_rdy drops to 0 after 2 entries.
  - No entry is lost; tags are committed in push order.
- wb_rdy stall: wb_rdy held 0 for 4 cycles at the completion point of a MUL.
  - Required: mext_vld=0 and operands stable during the stall.
  - Exactly one mext_vld pulse in the cycle wb_rdy returns to 1.
- Flush: flush asserted in cycle 4 of a DIV with one entry queued on req1.
  - Required: mext_vld never asserted for either op.
  - busy=0 in cycle 5; a new req1 request accepted in cycle 5 is granted in cycle 6.
- Reset mid-EXEC: rst asserted during EXEC.
  - Required: all outputs return to their reset values immediately; no mext_vld follows.
